// File: rtl/m_frame_buf_arbiter_pkg.sv
// Shared definitions for the frame buffer arbiter slice.
// Holds the FSM state encoding, the burst length width, the FIFO level width
// and the default frame/burst geometry.
package m_frame_buf_arbiter_pkg;

  localparam int unsigned C_ADDR_W      = 24;
  localparam int unsigned C_BURST_LEN   = 256;
  localparam int unsigned C_FRAME_WORDS = 307200;
  localparam int unsigned C_FIFO_DEPTH  = 1024;
  localparam int unsigned C_RD_URGENT   = 128;

  localparam int unsigned LEN_W   = 9;
  localparam int unsigned USEDW_W = 10;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_REQ   = 3'd1;
  localparam logic [2:0] S_WR_BURST = 3'd2;
  localparam logic [2:0] S_RD_REQ   = 3'd3;
  localparam logic [2:0] S_RD_BURST = 3'd4;

endpackage

// File: rtl/m_frame_buf_arbiter_if.sv
// Burst command bus between the arbiter and the SDRAM controller.
//  wr_req/rd_req : burst request, one direction at a time
//  addr          : burst start address {bank, offset}
//  burst_len     : words in the burst
//  ack           : controller accepted the command (1 cycle)
//  done          : burst data transfer complete (1 cycle)
// master = arbiter side, slave = controller side.
interface m_frame_buf_arbiter_if #(
  parameter int unsigned P_ADDR_W = 24
);
  import m_frame_buf_arbiter_pkg::*;

  logic                wr_req;
  logic                rd_req;
  logic [P_ADDR_W-1:0] addr;
  logic [LEN_W-1:0]    burst_len;
  logic                ack;
  logic                done;

  modport master (output wr_req, output rd_req, output addr, output burst_len,
                  input  ack,    input  done);
  modport slave  (input  wr_req, input  rd_req, input  addr, input  burst_len,
                  output ack,    output done);
endinterface

// File: rtl/m_frame_addr_gen.sv
// Frame address generator: one instance per direction.
// Keeps the word offset within the current frame and the bank bit.
//  i_restart   : offset <= 0
//  i_bank_load : bank <= i_bank
//  i_advance   : offset += i_len (burst completed)
//  o_addr      : {bank, offset}
//  o_next_len  : min(P_BURST_LEN, P_FRAME_WORDS - offset)
//  o_at_end    : the whole frame has been transferred
//  o_bank      : current bank
module m_frame_addr_gen
  import m_frame_buf_arbiter_pkg::*;
#(
  parameter int unsigned P_ADDR_W      = C_ADDR_W,
  parameter int unsigned P_BURST_LEN   = C_BURST_LEN,
  parameter int unsigned P_FRAME_WORDS = C_FRAME_WORDS
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_restart,
  input  logic                i_bank_load,
  input  logic                i_bank,
  input  logic                i_advance,
  input  logic [LEN_W-1:0]    i_len,
  output logic [P_ADDR_W-1:0] o_addr,
  output logic [LEN_W-1:0]    o_next_len,
  output logic                o_at_end,
  output logic                o_bank
);

  localparam int unsigned OW = P_ADDR_W - 1;
  localparam logic [OW-1:0] C_FRAME = OW'(P_FRAME_WORDS);
  localparam logic [OW-1:0] C_BURST = OW'(P_BURST_LEN);

  logic [OW-1:0] off;
  logic [OW-1:0] remaining;
  logic          bank;

  assign remaining  = C_FRAME - off;
  assign o_at_end   = (off >= C_FRAME);
  assign o_next_len = (remaining >= C_BURST) ? LEN_W'(P_BURST_LEN) : remaining[LEN_W-1:0];
  assign o_addr     = {bank, off};
  assign o_bank     = bank;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      off  <= '0;
      bank <= 1'b0;
    end else begin
      if (i_restart)
        off <= '0;
      else if (i_advance)
        off <= off + {{(OW-LEN_W){1'b0}}, i_len};
      if (i_bank_load)
        bank <= i_bank;
    end
  end

endmodule

// File: rtl/m_frame_buf_arbiter.sv
// SDRAM burst arbiter between the camera write path and the VGA read path.
// Picks one direction at a time from the FIFO levels, issues one burst
// command on the sdram bus and ping-pongs frame banks so the display always
// reads a complete frame.
//  i_clk, i_rst_n          : clock, asynchronous active-low reset
//  i_wr_fifo_usedw         : camera write FIFO level
//  i_wr_frame_start        : camera vsync pulse
//  i_rd_fifo_usedw         : display read FIFO level
//  i_rd_frame_clr          : display FIFO clear level (line 0)
//  sdram                   : burst command bus (master side)
//  o_busy                  : command pending or in flight
//  o_rd_bank               : bank currently being displayed
module m_frame_buf_arbiter
  import m_frame_buf_arbiter_pkg::*;
#(
  parameter int unsigned P_ADDR_W      = C_ADDR_W,
  parameter int unsigned P_BURST_LEN   = C_BURST_LEN,
  parameter int unsigned P_FRAME_WORDS = C_FRAME_WORDS,
  parameter int unsigned P_FIFO_DEPTH  = C_FIFO_DEPTH,
  parameter int unsigned P_RD_URGENT   = C_RD_URGENT
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [USEDW_W-1:0] i_wr_fifo_usedw,
  input  logic               i_wr_frame_start,
  input  logic [USEDW_W-1:0] i_rd_fifo_usedw,
  input  logic               i_rd_frame_clr,
  m_frame_buf_arbiter_if.master sdram,
  output logic               o_busy,
  output logic               o_rd_bank
);

  localparam int unsigned UW = USEDW_W + 1;
  localparam logic [UW-1:0] C_URGENT = UW'(P_RD_URGENT);
  localparam logic [UW-1:0] C_REFILL = UW'(P_FIFO_DEPTH - P_BURST_LEN);

  logic [2:0]          state;
  logic                wr_pend, rd_pend, full_bank, clr_d, wr_end_d;
  logic [P_ADDR_W-1:0] wr_addr, rd_addr;
  logic [LEN_W-1:0]    wr_len, rd_len;
  logic                wr_at_end, rd_at_end, wr_bank;
  logic                in_wr, in_rd, clr_rise, wr_restart, rd_restart;
  logic                full_bank_nxt, rd_bank_nxt, wr_bank_sel;
  logic                wr_advance, rd_advance, decide;
  logic                rd_ok, rd_urgent, rd_refill, wr_go;

  assign in_wr    = (state == S_WR_REQ) || (state == S_WR_BURST);
  assign in_rd    = (state == S_RD_REQ) || (state == S_RD_BURST);
  assign clr_rise = i_rd_frame_clr & ~clr_d;

  // Restarts are held pending while their own direction is in flight.
  assign wr_restart = (i_wr_frame_start | wr_pend) & ~in_wr;
  assign rd_restart = (clr_rise | rd_pend) & ~in_rd;

  // The frame-complete bank is forwarded so a restart in the very cycle the
  // write frame ends already sees the new full bank.
  assign full_bank_nxt = (wr_at_end & ~wr_end_d) ? wr_bank : full_bank;
  assign rd_bank_nxt   = rd_restart ? full_bank_nxt : rd_bank_nxt_hold();
  assign wr_bank_sel   = (~full_bank_nxt == rd_bank_nxt) ? full_bank_nxt : ~full_bank_nxt;

  function automatic logic rd_bank_nxt_hold();
    return o_rd_bank;
  endfunction

  assign wr_advance = (state == S_WR_BURST) & sdram.done;
  assign rd_advance = (state == S_RD_BURST) & sdram.done;

  // No decision in a restart cycle so the command never carries a stale address.
  assign decide    = (state == S_IDLE) & ~wr_restart & ~rd_restart;
  assign rd_ok     = ~rd_at_end & ~i_rd_frame_clr;
  assign rd_urgent = rd_ok & ({1'b0, i_rd_fifo_usedw} < C_URGENT);
  assign rd_refill = rd_ok & ({1'b0, i_rd_fifo_usedw} <= C_REFILL);
  assign wr_go     = ~wr_at_end & ({1'b0, i_wr_fifo_usedw} >= {{(UW-LEN_W){1'b0}}, wr_len});

  assign o_busy = (state != S_IDLE);

  m_frame_addr_gen #(
    .P_ADDR_W      (P_ADDR_W),
    .P_BURST_LEN   (P_BURST_LEN),
    .P_FRAME_WORDS (P_FRAME_WORDS)
  ) u_wr_gen (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_restart   (wr_restart),
    .i_bank_load (wr_restart),
    .i_bank      (wr_bank_sel),
    .i_advance   (wr_advance),
    .i_len       (sdram.burst_len),
    .o_addr      (wr_addr),
    .o_next_len  (wr_len),
    .o_at_end    (wr_at_end),
    .o_bank      (wr_bank)
  );

  m_frame_addr_gen #(
    .P_ADDR_W      (P_ADDR_W),
    .P_BURST_LEN   (P_BURST_LEN),
    .P_FRAME_WORDS (P_FRAME_WORDS)
  ) u_rd_gen (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_restart   (rd_restart),
    .i_bank_load (rd_restart),
    .i_bank      (full_bank_nxt),
    .i_advance   (rd_advance),
    .i_len       (sdram.burst_len),
    .o_addr      (rd_addr),
    .o_next_len  (rd_len),
    .o_at_end    (rd_at_end),
    .o_bank      (o_rd_bank)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= S_IDLE;
      wr_pend         <= 1'b0;
      rd_pend         <= 1'b0;
      full_bank       <= 1'b0;
      clr_d           <= 1'b0;
      wr_end_d        <= 1'b0;
      sdram.wr_req    <= 1'b0;
      sdram.rd_req    <= 1'b0;
      sdram.addr      <= '0;
      sdram.burst_len <= '0;
    end else begin
      clr_d     <= i_rd_frame_clr;
      wr_end_d  <= wr_at_end;
      full_bank <= full_bank_nxt;
      wr_pend   <= in_wr & (wr_pend | i_wr_frame_start);
      rd_pend   <= in_rd & (rd_pend | clr_rise);
      case (state)
        S_IDLE: begin
          if (decide) begin
            if (rd_urgent) begin
              sdram.rd_req    <= 1'b1;
              sdram.addr      <= rd_addr;
              sdram.burst_len <= rd_len;
              state           <= S_RD_REQ;
            end else if (wr_go) begin
              sdram.wr_req    <= 1'b1;
              sdram.addr      <= wr_addr;
              sdram.burst_len <= wr_len;
              state           <= S_WR_REQ;
            end else if (rd_refill) begin
              sdram.rd_req    <= 1'b1;
              sdram.addr      <= rd_addr;
              sdram.burst_len <= rd_len;
              state           <= S_RD_REQ;
            end
          end
        end
        S_WR_REQ: begin
          if (sdram.ack) begin
            sdram.wr_req <= 1'b0;
            state        <= S_WR_BURST;
          end
        end
        S_RD_REQ: begin
          if (sdram.ack) begin
            sdram.rd_req <= 1'b0;
            state        <= S_RD_BURST;
          end
        end
        S_WR_BURST, S_RD_BURST: begin
          if (sdram.done)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_frame_buf_arbiter.sv
// Directed bench for m_frame_buf_arbiter with a 600-word frame so that
// complete frames and short tail bursts stay short.
module tb_m_frame_buf_arbiter;

  localparam int unsigned AW = 24;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] wr_used = '0;
  logic [9:0] rd_used = 10'd1023;
  logic       wr_fs = 1'b0;
  logic       clr = 1'b0;
  logic       busy, rd_bank;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  m_frame_buf_arbiter_if #(.P_ADDR_W(AW)) bus ();

  m_frame_buf_arbiter #(
    .P_ADDR_W      (AW),
    .P_FRAME_WORDS (600)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_wr_fifo_usedw  (wr_used),
    .i_wr_frame_start (wr_fs),
    .i_rd_fifo_usedw  (rd_used),
    .i_rd_frame_clr   (clr),
    .sdram            (bus),
    .o_busy           (busy),
    .o_rd_bank        (rd_bank)
  );

  task automatic do_reset();
    rst_n = 1'b0; wr_used = '0; rd_used = 10'd1023; wr_fs = 1'b0; clr = 1'b0;
    bus.ack = 1'b0; bus.done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_req(output logic w, output logic r, output logic to);
    to = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (bus.wr_req || bus.rd_req) begin
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    w = bus.wr_req;
    r = bus.rd_req;
  endtask

  task automatic do_burst(input logic fs_mid, input logic clr_mid,
                          output logic dropped, output logic [AW-1:0] addr_mid);
    bus.ack = 1'b1;
    @(posedge clk); #1;
    bus.ack = 1'b0;
    dropped = !bus.wr_req && !bus.rd_req && busy;
    wr_fs = fs_mid;
    if (clr_mid) clr = 1'b1;
    @(posedge clk); #1;
    wr_fs = 1'b0;
    addr_mid = bus.addr;
    bus.done = 1'b1;
    @(posedge clk); #1;
    bus.done = 1'b0;
  endtask

  task automatic pulse_fs();
    wr_fs = 1'b1;
    @(posedge clk); #1;
    wr_fs = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_frame(output logic [AW-1:0] first, output logic any_to);
    logic w, r, to, dr;
    logic [AW-1:0] am;
    any_to = 1'b0;
    first = '0;
    wr_used = 10'd300;
    for (int i = 0; i < 3; i++) begin
      wait_req(w, r, to);
      if (to || !w) any_to = 1'b1;
      if (i == 0) first = bus.addr;
      do_burst(1'b0, 1'b0, dr, am);
    end
    wr_used = '0;
  endtask

  task automatic test_reset();
    do_reset();
    idle_cycles(2);
    total++; if (bus.wr_req !== 1'b0) begin bad++; $display("FAIL rst_wr_req got=%b want=0", bus.wr_req); end
    total++; if (bus.rd_req !== 1'b0) begin bad++; $display("FAIL rst_rd_req got=%b want=0", bus.rd_req); end
    total++; if (bus.addr !== 24'h0) begin bad++; $display("FAIL rst_addr got=%h want=000000", bus.addr); end
    total++; if (bus.burst_len !== 9'd0) begin bad++; $display("FAIL rst_len got=%0d want=0", bus.burst_len); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (rd_bank !== 1'b0) begin bad++; $display("FAIL rst_rd_bank got=%b want=0", rd_bank); end
  endtask

  task automatic test_write();
    logic w, r, to, dr;
    logic [AW-1:0] am;
    do_reset();
    wr_used = 10'd300;
    wait_req(w, r, to);
    total++; if (to || w !== 1'b1 || r !== 1'b0) begin bad++; $display("FAIL t1_req got w=%b r=%b to=%b want w=1 r=0", w, r, to); end
    total++; if (bus.addr !== 24'h000000) begin bad++; $display("FAIL t1_addr0 got=%h want=000000", bus.addr); end
    total++; if (bus.burst_len !== 9'd256) begin bad++; $display("FAIL t1_len0 got=%0d want=256", bus.burst_len); end
    idle_cycles(3);
    total++; if (bus.wr_req !== 1'b1 || bus.addr !== 24'h0) begin bad++; $display("FAIL t1_hold got req=%b addr=%h want req=1 addr=000000", bus.wr_req, bus.addr); end
    do_burst(1'b0, 1'b0, dr, am);
    total++; if (dr !== 1'b1) begin bad++; $display("FAIL t1_req_drop got=%b want=1", dr); end
    wait_req(w, r, to);
    total++; if (to || w !== 1'b1 || bus.addr !== 24'h000100) begin bad++; $display("FAIL t1_addr1 got=%h w=%b to=%b want=000100", bus.addr, w, to); end
    do_burst(1'b0, 1'b0, dr, am);
    wr_used = '0;
    pulse_fs();
    wr_used = 10'd300;
    wait_req(w, r, to);
    total++; if (to || w !== 1'b1 || bus.addr !== 24'h800000) begin bad++; $display("FAIL t1_fs_addr got=%h w=%b to=%b want=800000", bus.addr, w, to); end
  endtask

  task automatic test_priority();
    logic w, r, to, dr;
    logic [AW-1:0] am;
    do_reset();
    rd_used = 10'd100; wr_used = 10'd512;
    wait_req(w, r, to);
    total++; if (to || r !== 1'b1 || w !== 1'b0 || bus.addr !== 24'h0) begin bad++; $display("FAIL t2_urgent got r=%b w=%b addr=%h want r=1 w=0 addr=000000", r, w, bus.addr); end
    do_burst(1'b0, 1'b0, dr, am);
    rd_used = 10'd1023;
    wait_req(w, r, to);
    total++; if (to || w !== 1'b1 || bus.addr !== 24'h0) begin bad++; $display("FAIL t2_write_after got w=%b addr=%h want w=1 addr=000000", w, bus.addr); end
    do_burst(1'b0, 1'b0, dr, am);
    wr_used = '0; rd_used = 10'd769;
    idle_cycles(4);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t2_no_refill_769 got busy=%b want=0", busy); end
    rd_used = 10'd768;
    wait_req(w, r, to);
    total++; if (to || r !== 1'b1 || bus.addr !== 24'h000100) begin bad++; $display("FAIL t2_refill_768 got r=%b addr=%h want r=1 addr=000100", r, bus.addr); end
    do_burst(1'b0, 1'b0, dr, am);
    wr_used = 10'd512; rd_used = 10'd128;
    wait_req(w, r, to);
    total++; if (to || w !== 1'b1 || bus.addr !== 24'h000100) begin bad++; $display("FAIL t2_rd128_write got w=%b addr=%h want w=1 addr=000100", w, bus.addr); end
    do_burst(1'b0, 1'b0, dr, am);
    rd_used = 10'd127;
    wait_req(w, r, to);
    total++; if (to || r !== 1'b1 || bus.addr !== 24'h000200 || bus.burst_len !== 9'd88) begin bad++; $display("FAIL t2_rd127_urgent got r=%b addr=%h len=%0d want r=1 addr=000200 len=88", r, bus.addr, bus.burst_len); end
    do_burst(1'b0, 1'b0, dr, am);
    rd_used = 10'd0;
    wait_req(w, r, to);
    total++; if (to || w !== 1'b1 || r !== 1'b0 || bus.addr !== 24'h000200) begin bad++; $display("FAIL t2_rd_at_end got w=%b r=%b addr=%h want w=1 r=0 addr=000200", w, r, bus.addr); end
    do_burst(1'b0, 1'b0, dr, am);
  endtask

  task automatic test_frame_tail();
    logic w, r, to, dr;
    logic [AW-1:0] am;
    do_reset();
    wr_used = 10'd300;
    wait_req(w, r, to);
    total++; if (to || bus.burst_len !== 9'd256) begin bad++; $display("FAIL t3_len0 got=%0d want=256", bus.burst_len); end
    do_burst(1'b0, 1'b0, dr, am);
    wait_req(w, r, to);
    total++; if (to || bus.burst_len !== 9'd256 || bus.addr !== 24'h000100) begin bad++; $display("FAIL t3_len1 got len=%0d addr=%h want 256 000100", bus.burst_len, bus.addr); end
    do_burst(1'b0, 1'b0, dr, am);
    wr_used = 10'd87;
    idle_cycles(4);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t3_used87 got busy=%b want=0", busy); end
    wr_used = 10'd88;
    wait_req(w, r, to);
    total++; if (to || w !== 1'b1 || bus.burst_len !== 9'd88 || bus.addr !== 24'h000200) begin bad++; $display("FAIL t3_tail got w=%b len=%0d addr=%h want 1 88 000200", w, bus.burst_len, bus.addr); end
    do_burst(1'b0, 1'b0, dr, am);
    wr_used = 10'd300;
    idle_cycles(5);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t3_at_end got busy=%b want=0", busy); end
    pulse_fs();
    wait_req(w, r, to);
    total++; if (to || w !== 1'b1 || bus.addr !== 24'h800000 || bus.burst_len !== 9'd256) begin bad++; $display("FAIL t3_restart got w=%b addr=%h len=%0d want 1 800000 256", w, bus.addr, bus.burst_len); end
  endtask

  task automatic test_ping_pong();
    logic w, r, to, dr;
    logic [AW-1:0] am, first;
    do_reset();
    write_frame(first, to);
    total++; if (to || first !== 24'h000000) begin bad++; $display("FAIL t4_frame0 got=%h to=%b want=000000", first, to); end
    clr = 1'b1; idle_cycles(3); clr = 1'b0;
    rd_used = 10'd100;
    wait_req(w, r, to);
    total++; if (to || r !== 1'b1 || bus.addr !== 24'h000000 || rd_bank !== 1'b0) begin bad++; $display("FAIL t4_read0 got r=%b addr=%h bank=%b want 1 000000 0", r, bus.addr, rd_bank); end
    do_burst(1'b0, 1'b0, dr, am);
    rd_used = 10'd1023;
    pulse_fs();
    write_frame(first, to);
    total++; if (to || first !== 24'h800000) begin bad++; $display("FAIL t4_frame1 got=%h to=%b want=800000", first, to); end
    clr = 1'b1; idle_cycles(3); clr = 1'b0;
    total++; if (rd_bank !== 1'b1) begin bad++; $display("FAIL t4_rd_bank1 got=%b want=1", rd_bank); end
    rd_used = 10'd100;
    wait_req(w, r, to);
    total++; if (to || r !== 1'b1 || bus.addr !== 24'h800000) begin bad++; $display("FAIL t4_read1 got r=%b addr=%h want 1 800000", r, bus.addr); end
    do_burst(1'b0, 1'b0, dr, am);
    rd_used = 10'd1023;
    pulse_fs();
    write_frame(first, to);
    total++; if (to || first !== 24'h000000) begin bad++; $display("FAIL t4_frame2 got=%h to=%b want=000000", first, to); end
    pulse_fs();
    write_frame(first, to);
    total++; if (to || first !== 24'h000000) begin bad++; $display("FAIL t4_collision got=%h to=%b want=000000", first, to); end
  endtask

  task automatic test_deferral();
    logic w, r, to, dr;
    logic [AW-1:0] am;
    do_reset();
    wr_used = 10'd300;
    wait_req(w, r, to);
    do_burst(1'b1, 1'b0, dr, am);
    total++; if (to || am !== 24'h000000) begin bad++; $display("FAIL t5_wr_mid_addr got=%h to=%b want=000000", am, to); end
    wait_req(w, r, to);
    total++; if (to || w !== 1'b1 || bus.addr !== 24'h800000) begin bad++; $display("FAIL t5_wr_deferred got w=%b addr=%h want 1 800000", w, bus.addr); end
    do_burst(1'b0, 1'b0, dr, am);
    wr_used = '0; rd_used = 10'd100;
    wait_req(w, r, to);
    total++; if (to || r !== 1'b1 || bus.addr !== 24'h000000) begin bad++; $display("FAIL t5_rd_first got r=%b addr=%h want 1 000000", r, bus.addr); end
    do_burst(1'b0, 1'b1, dr, am);
    total++; if (am !== 24'h000000) begin bad++; $display("FAIL t5_rd_mid_addr got=%h want=000000", am); end
    idle_cycles(4);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t5_clr_blocks got busy=%b want=0", busy); end
    clr = 1'b0;
    wait_req(w, r, to);
    total++; if (to || r !== 1'b1 || bus.addr !== 24'h000000) begin bad++; $display("FAIL t5_rd_deferred got r=%b addr=%h want 1 000000", r, bus.addr); end
  endtask

  task automatic test_reset_mid();
    logic w, r, to, dr;
    logic [AW-1:0] am;
    do_reset();
    bus.ack = 1'b1; bus.done = 1'b1;
    idle_cycles(1);
    bus.ack = 1'b0; bus.done = 1'b0;
    idle_cycles(1);
    total++; if (busy !== 1'b0 || bus.wr_req !== 1'b0 || bus.rd_req !== 1'b0) begin bad++; $display("FAIL t6_stray got busy=%b wr=%b rd=%b want 0 0 0", busy, bus.wr_req, bus.rd_req); end
    rd_used = 10'd100;
    wait_req(w, r, to);
    do_burst(1'b0, 1'b0, dr, am);
    wait_req(w, r, to);
    total++; if (to || r !== 1'b1 || bus.addr !== 24'h000100) begin bad++; $display("FAIL t6_second_rd got r=%b addr=%h want 1 000100", r, bus.addr); end
    rst_n = 1'b0;
    #2;
    total++; if (bus.rd_req !== 1'b0 || bus.wr_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL t6_async_req got rd=%b wr=%b busy=%b want 0 0 0", bus.rd_req, bus.wr_req, busy); end
    total++; if (bus.addr !== 24'h0 || bus.burst_len !== 9'd0) begin bad++; $display("FAIL t6_async_bus got addr=%h len=%0d want 000000 0", bus.addr, bus.burst_len); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_req(w, r, to);
    total++; if (to || r !== 1'b1 || bus.addr !== 24'h000000) begin bad++; $display("FAIL t6_after_rst got r=%b addr=%h want 1 000000", r, bus.addr); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_priority();
    test_frame_tail();
    test_ping_pong();
    test_deferral();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
